// File: rtl/sysid_checker.sv
`default_nettype none
// ============================================================================
// Module   : sysid_checker
// Purpose  : Reads the ID and timestamp words from an Avalon-MM sysid slave
//            and compares them against the expected build values.
// Revision : 1.0 - initial release
// ============================================================================
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1520875055,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Counter value seen in the last tolerated stall cycle of a read.
    localparam logic [7:0] C_WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        timeout_q, timeout_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        timeout_d  = timeout_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RD_ID;
                    wait_d    = 8'd0;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            RD_ID, RD_TS: begin
                if (!avm_waitrequest) begin
                    wait_d = 8'd0;
                    if (state_q == RD_ID) begin
                        id_value_d = avm_readdata;
                        id_ok_d    = (avm_readdata == EXPECTED_ID);
                        state_d    = RD_TS;
                    end else begin
                        ts_value_d = avm_readdata;
                        ts_ok_d    = (avm_readdata == EXPECTED_TS);
                        state_d    = DONE;
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                    // Abort: captured words are left as they were.
                    if (wait_q == C_WAIT_LAST) begin
                        timeout_d = 1'b1;
                        id_ok_d   = 1'b0;
                        ts_ok_d   = 1'b0;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wait_q     <= 8'd0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            timeout_q  <= 1'b0;
            id_value_q <= 32'd0;
            ts_value_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            timeout_q  <= timeout_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
        end
    end

    // Bus strobes are pure state decodes, so they cannot move during a stall.
    assign busy        = (state_q == RD_ID) || (state_q == RD_TS);
    assign avm_read    = busy;
    assign avm_address = (state_q == RD_TS);
    assign done        = (state_q == DONE);
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = timeout_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;

endmodule
`default_nettype wire
